// File: rtl/fb_blend_responder_pkg.sv
// Shared types for the framebuffer blend responder: pixel colour struct, FSM state encoding, frame geometry.
package fb_pkg;

  localparam int FB_W = 640;
  localparam int FB_H = 480;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SWAP  = 2'd1,
    CLEAR = 2'd2
  } fb_state_t;

  function automatic rgb_t pack_rgb(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    rgb_t c;
    c.r = r;
    c.g = g;
    c.b = b;
    return c;
  endfunction

endpackage

// File: rtl/fb_blend_responder_addr_pipe.sv
// Delay line carrying {valid, pixel address, destination colour} from read to write,
// patching in-flight colours whenever a write lands on the same pixel.
module fb_addr_pipe #(
  parameter int STAGES = 2,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_vld,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [23:0]       rdata,
  input  logic              wr_commit,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  output logic              last_vld,
  output logic [ADDR_W-1:0] last_addr,
  output logic [23:0]       last_rgb,
  output logic              any_vld
);

  logic [STAGES-1:0] vld_p;
  logic [STAGES-1:0] hit;
  logic [ADDR_W-1:0] addr_p [STAGES];
  logic [23:0]       rgb_p  [STAGES];
  logic              fwd_p0;

  always_comb begin
    any_vld = 1'b0;
    hit     = '0;
    for (int k = 0; k < STAGES; k++) begin
      hit[k]  = wr_commit && vld_p[k] && (addr_p[k] == wr_addr);
      any_vld = any_vld | vld_p[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_p  <= '0;
      fwd_p0 <= 1'b0;
    end else begin
      vld_p[0] <= in_vld;
      // RAM read in the same cycle as a write to that pixel returns stale data
      fwd_p0   <= in_vld && wr_commit && (in_addr == wr_addr);
      for (int k = 1; k < STAGES; k++) begin
        vld_p[k] <= vld_p[k-1];
      end
    end
  end

  // stage 0 -> stage 1 picks up RAM data; later stages just shift
  always_ff @(posedge clk) begin
    addr_p[0] <= in_addr;
    rgb_p[0]  <= wr_data;
    for (int k = 1; k < STAGES; k++) begin
      addr_p[k] <= addr_p[k-1];
      if (hit[k-1])
        rgb_p[k] <= wr_data;
      else if (k == 1)
        rgb_p[k] <= fwd_p0 ? rgb_p[0] : rdata;
      else
        rgb_p[k] <= rgb_p[k-1];
    end
  end

  assign last_vld  = vld_p[STAGES-1];
  assign last_addr = addr_p[STAGES-1];
  assign last_rgb  = (STAGES == 1) ? (fwd_p0 ? rgb_p[0] : rdata) : rgb_p[STAGES-1];

endmodule

// File: rtl/fb_blend_responder.sv
// Framebuffer responder for the alpha blender's read-modify-write stream, with double-buffer swap.
// Define FB_CLEAR_ON_SWAP_EN to fill the new draw bank with BG_COLOR after every swap.
module fb_blend_responder
  import fb_pkg::*;
#(
  parameter int          CLKWAIT  = 2,
  parameter int          ADDR_W   = 19,
  parameter int          PIXELS   = 307200,
  parameter logic [23:0] BG_COLOR = 24'h000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pixel_number,
  input  logic              read,
  input  logic              write,
  input  logic [7:0]        write_r,
  input  logic [7:0]        write_g,
  input  logic [7:0]        write_b,
  input  logic              frame_ready,
  output logic [7:0]        read_r,
  output logic [7:0]        read_g,
  output logic [7:0]        read_b,
  output logic              busy,
  output logic              overrun,
  output logic              display_bank,
  output logic              mem_rd_en,
  output logic [ADDR_W:0]   mem_rd_addr,
  input  logic [23:0]       mem_rdata,
  output logic              mem_wr_en,
  output logic [ADDR_W:0]   mem_wr_addr,
  output logic [23:0]       mem_wdata
);

  fb_state_t         state;
  logic              swap_pend;
  logic              draw_bank;
  logic [23:0]       rd_hold;
  logic              accept;
  logic              wr_commit;
  logic              last_vld;
  logic [ADDR_W-1:0] last_addr;
  logic [23:0]       last_rgb;
  logic              any_vld;
  rgb_t              wr_rgb;

`ifdef FB_CLEAR_ON_SWAP_EN
  logic [ADDR_W-1:0] clr_cnt;
`endif

  assign busy      = swap_pend || (state != RUN);
  assign accept    = reset && read && !busy;
  assign wr_commit = reset && write && last_vld;
  assign wr_rgb    = pack_rgb(write_r, write_g, write_b);

  assign mem_rd_en   = accept;
  assign mem_rd_addr = accept ? {draw_bank, pixel_number} : '0;

  always_comb begin
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_wdata   = '0;
    if (wr_commit) begin
      mem_wr_en   = 1'b1;
      mem_wr_addr = {draw_bank, last_addr};
      mem_wdata   = wr_rgb;
    end
`ifdef FB_CLEAR_ON_SWAP_EN
    if (reset && state == CLEAR) begin
      mem_wr_en   = 1'b1;
      mem_wr_addr = {draw_bank, clr_cnt};
      mem_wdata   = BG_COLOR;
    end
`endif
  end

  fb_addr_pipe #(
    .STAGES(CLKWAIT),
    .ADDR_W(ADDR_W)
  ) u_pipe (
    .clk      (clk),
    .reset    (reset),
    .in_vld   (accept),
    .in_addr  (pixel_number),
    .rdata    (mem_rdata),
    .wr_commit(wr_commit),
    .wr_addr  (last_addr),
    .wr_data  (wr_rgb),
    .last_vld (last_vld),
    .last_addr(last_addr),
    .last_rgb (last_rgb),
    .any_vld  (any_vld)
  );

  assign {read_r, read_g, read_b} = last_vld ? last_rgb : rd_hold;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= RUN;
      swap_pend    <= 1'b0;
      draw_bank    <= 1'b0;
      display_bank <= 1'b1;
      overrun      <= 1'b0;
      rd_hold      <= '0;
`ifdef FB_CLEAR_ON_SWAP_EN
      clr_cnt      <= '0;
`endif
    end else begin
      if (read && busy)
        overrun <= 1'b1;
      if (last_vld)
        rd_hold <= last_rgb;
      // a frame_ready arriving during SWAP must survive the clear of swap_pend
      swap_pend <= frame_ready | (swap_pend & (state != SWAP));
      case (state)
        RUN: begin
          if (swap_pend && !any_vld)
            state <= SWAP;
        end
        SWAP: begin
          draw_bank    <= ~draw_bank;
          display_bank <= ~display_bank;
`ifdef FB_CLEAR_ON_SWAP_EN
          clr_cnt      <= '0;
          state        <= CLEAR;
`else
          state        <= RUN;
`endif
        end
`ifdef FB_CLEAR_ON_SWAP_EN
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == ADDR_W'(PIXELS - 1))
            state <= RUN;
        end
`endif
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_blend_responder.sv
// Directed bench for fb_blend_responder with a behavioural 1-cycle-latency pixel RAM.
// Clear-on-swap scenarios run when FB_CLEAR_ON_SWAP_EN is defined.
module tb_fb_blend_responder;

  localparam int          AW  = 19;
  localparam int          PIX = 1200;
  localparam logic [23:0] BG  = 24'h102030;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] pixel_number;
  logic          read, write, frame_ready;
  logic [7:0]    write_r, write_g, write_b;
  logic [7:0]    read_r, read_g, read_b;
  logic          busy, overrun, display_bank;
  logic          mem_rd_en, mem_wr_en;
  logic [AW:0]   mem_rd_addr, mem_wr_addr;
  logic [23:0]   mem_rdata, mem_wdata;
  logic [23:0]   rd_rgb;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [23:0] ram [int];

  assign rd_rgb = {read_r, read_g, read_b};

  fb_blend_responder #(
    .CLKWAIT(2), .ADDR_W(AW), .PIXELS(PIX), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .reset(reset), .pixel_number(pixel_number), .read(read), .write(write),
    .write_r(write_r), .write_g(write_g), .write_b(write_b), .frame_ready(frame_ready),
    .read_r(read_r), .read_g(read_g), .read_b(read_b), .busy(busy), .overrun(overrun),
    .display_bank(display_bank), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rdata(mem_rdata), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] ram_get(input int a);
    return ram.exists(a) ? ram[a] : 24'h0;
  endfunction

  function automatic int baddr(input int b, input int p);
    return (b << AW) | p;
  endfunction

  // read-before-write RAM model
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= ram_get(int'(mem_rd_addr));
    if (mem_wr_en) ram[int'(mem_wr_addr)] = mem_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic [23:0] c);
    {write_r, write_g, write_b} = c;
  endtask

  task automatic test_reset();
    reset = 1'b0; read = 0; write = 0; frame_ready = 0; pixel_number = '0; set_wr(24'h0);
    repeat (3) tick();
    @(negedge clk);
    tests_run++; if (display_bank !== 1'b1) begin tests_failed++; $display("FAIL reset_display_bank: got %b want 1", display_bank); end
    tests_run++; if ({busy, overrun, mem_rd_en, mem_wr_en} !== 4'b0) begin tests_failed++; $display("FAIL reset_flags: got %b want 0000", {busy, overrun, mem_rd_en, mem_wr_en}); end
    tests_run++; if (rd_rgb !== 24'h0) begin tests_failed++; $display("FAIL reset_read_rgb: got %h want 000000", rd_rgb); end
    tests_run++; if ({mem_rd_addr, mem_wr_addr, mem_wdata} !== '0) begin tests_failed++; $display("FAIL reset_mem_bus: got %h/%h/%h want 0", mem_rd_addr, mem_wr_addr, mem_wdata); end
    tick(); reset = 1'b1;
    tick();
  endtask

  task automatic test_single_rmw();
    ram[baddr(0, 100)] = 24'h112233;
    tick(); read = 1; pixel_number = 100;
    @(negedge clk);
    tests_run++; if (mem_rd_en !== 1'b1 || mem_rd_addr !== 20'(baddr(0, 100))) begin tests_failed++; $display("FAIL single_rd_req: got en=%b addr=%h want en=1 addr=%h", mem_rd_en, mem_rd_addr, 20'(baddr(0, 100))); end
    tick(); read = 0;
    tick(); write = 1; set_wr(24'hAABBCC);
    @(negedge clk);
    tests_run++; if (rd_rgb !== 24'h112233) begin tests_failed++; $display("FAIL single_read_rgb: got %h want 112233", rd_rgb); end
    tests_run++; if (mem_wr_en !== 1'b1 || mem_wr_addr !== 20'(baddr(0, 100)) || mem_wdata !== 24'hAABBCC) begin tests_failed++; $display("FAIL single_wr_bus: got en=%b addr=%h data=%h want 1/%h/aabbcc", mem_wr_en, mem_wr_addr, mem_wdata, 20'(baddr(0, 100))); end
    tick(); write = 0;
    @(negedge clk);
    tests_run++; if (ram_get(baddr(0, 100)) !== 24'hAABBCC) begin tests_failed++; $display("FAIL single_ram_commit: got %h want aabbcc", ram_get(baddr(0, 100))); end
    tests_run++; if (rd_rgb !== 24'h112233) begin tests_failed++; $display("FAIL single_read_hold: got %h want 112233", rd_rgb); end
  endtask

  task automatic test_back_to_back();
    for (int p = 5; p <= 7; p++) ram[baddr(0, p)] = {3{8'(p)}};
    for (int i = 0; i < 5; i++) begin
      tick();
      read = (i < 3); pixel_number = AW'(5 + i);
      write = (i >= 2); set_wr(24'hA00000 + 24'(i + 3));
      @(negedge clk);
      if (i >= 2) begin
        tests_run++; if (rd_rgb !== {3{8'(i + 3)}}) begin tests_failed++; $display("FAIL b2b_read_rgb[%0d]: got %h want %h", i + 3, rd_rgb, {3{8'(i + 3)}}); end
        tests_run++; if (mem_wr_en !== 1'b1 || mem_wr_addr !== 20'(baddr(0, i + 3))) begin tests_failed++; $display("FAIL b2b_wr_addr[%0d]: got en=%b addr=%h", i + 3, mem_wr_en, mem_wr_addr); end
      end
    end
    tick(); read = 0; write = 0;
    @(negedge clk);
    for (int p = 5; p <= 7; p++) begin
      tests_run++; if (ram_get(baddr(0, p)) !== 24'hA00000 + 24'(p)) begin tests_failed++; $display("FAIL b2b_ram[%0d]: got %h want %h", p, ram_get(baddr(0, p)), 24'hA00000 + 24'(p)); end
    end
  endtask

  task automatic test_forwarding();
    logic [23:0] exp_rd [5];
    logic [23:0] wdat   [5];
    ram[baddr(0, 9)] = 24'h090909;
    // three same-pixel reads back-to-back; the third also meets a write to stage 0
    exp_rd = '{24'h0, 24'h0, 24'h090909, 24'h111111, 24'h222222};
    wdat   = '{24'h0, 24'h0, 24'h111111, 24'h222222, 24'h333333};
    for (int i = 0; i < 5; i++) begin
      tick();
      read = (i < 3); pixel_number = 9;
      write = (i >= 2); set_wr(wdat[i]);
      @(negedge clk);
      if (i >= 2) begin
        tests_run++; if (rd_rgb !== exp_rd[i]) begin tests_failed++; $display("FAIL fwd_chain_rgb[%0d]: got %h want %h", i, rd_rgb, exp_rd[i]); end
      end
    end
    // a read issued in the very cycle its pixel is written
    exp_rd = '{24'h0, 24'h0, 24'h333333, 24'h0, 24'h444444};
    wdat   = '{24'h0, 24'h0, 24'h444444, 24'h0, 24'h555555};
    for (int i = 0; i < 5; i++) begin
      tick();
      read = (i == 0 || i == 2); pixel_number = 9;
      write = (i == 2 || i == 4); set_wr(wdat[i]);
      @(negedge clk);
      if (write) begin
        tests_run++; if (rd_rgb !== exp_rd[i]) begin tests_failed++; $display("FAIL fwd_same_cycle_rgb[%0d]: got %h want %h", i, rd_rgb, exp_rd[i]); end
      end
    end
    tick(); read = 0; write = 0;
    @(negedge clk);
    tests_run++; if (ram_get(baddr(0, 9)) !== 24'h555555) begin tests_failed++; $display("FAIL fwd_ram_final: got %h want 555555", ram_get(baddr(0, 9))); end
  endtask

  task automatic test_write_ignored();
    tick(); write = 1; set_wr(24'hDEAD00);
    @(negedge clk);
    tests_run++; if (mem_wr_en !== 1'b0) begin tests_failed++; $display("FAIL orphan_write: got wr_en=%b want 0", mem_wr_en); end
    tick(); write = 0;
  endtask

  task automatic test_swap();
    int n;
    tick(); read = 1; pixel_number = 20;
    tick(); read = 1; pixel_number = 21; frame_ready = 1;
    @(negedge clk);
    tests_run++; if (mem_rd_en !== 1'b1) begin tests_failed++; $display("FAIL swap_read_with_frame_ready: got rd_en=%b want 1", mem_rd_en); end
    tick(); read = 0; frame_ready = 0; write = 1; set_wr(24'h202020);
    @(negedge clk);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL swap_busy_pending: got %b want 1", busy); end
    tests_run++; if (mem_wr_en !== 1'b1 || mem_wr_addr !== 20'(baddr(0, 20))) begin tests_failed++; $display("FAIL swap_drain_wr0: got en=%b addr=%h", mem_wr_en, mem_wr_addr); end
    tick(); set_wr(24'h212121);
    @(negedge clk);
    tests_run++; if (mem_wr_en !== 1'b1 || mem_wr_addr !== 20'(baddr(0, 21))) begin tests_failed++; $display("FAIL swap_drain_wr1: got en=%b addr=%h", mem_wr_en, mem_wr_addr); end
    tick(); write = 0;
    @(negedge clk);
    n = 0;
    while (display_bank !== 1'b0 && n < 20) begin
      tick(); @(negedge clk); n++;
    end
    tests_run++; if (n >= 20) begin tests_failed++; $display("FAIL swap_timeout: display_bank=%b after %0d cycles", display_bank, n); end
`ifndef FB_CLEAR_ON_SWAP_EN
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL swap_busy_after: got %b want 0", busy); end
    tick(); read = 1; pixel_number = 3;
    @(negedge clk);
    tests_run++; if (mem_rd_addr !== 20'(baddr(1, 3))) begin tests_failed++; $display("FAIL swap_new_draw_bank: got %h want %h", mem_rd_addr, 20'(baddr(1, 3))); end
    tick(); read = 0;
    repeat (3) tick();
`else
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL swap_busy_clear: got %b want 1", busy); end
`endif
  endtask

`ifndef FB_CLEAR_ON_SWAP_EN
  task automatic test_overrun();
    int n;
    tick(); frame_ready = 1;
    tick(); frame_ready = 0; read = 1; pixel_number = 4;
    @(negedge clk);
    tests_run++; if (busy !== 1'b1 || mem_rd_en !== 1'b0) begin tests_failed++; $display("FAIL overrun_no_access: got busy=%b rd_en=%b want 1/0", busy, mem_rd_en); end
    tick(); read = 0;
    @(negedge clk);
    tests_run++; if (overrun !== 1'b1) begin tests_failed++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
    n = 0;
    while (display_bank !== 1'b1 && n < 20) begin
      tick(); @(negedge clk); n++;
    end
    tests_run++; if (n >= 20 || busy !== 1'b0) begin tests_failed++; $display("FAIL overrun_swap_back: display_bank=%b busy=%b after %0d cycles", display_bank, busy, n); end
    tick(); reset = 0;
    tick(); reset = 1;
    @(negedge clk);
    tests_run++; if (overrun !== 1'b0 || display_bank !== 1'b1) begin tests_failed++; $display("FAIL overrun_reset: got overrun=%b display_bank=%b want 0/1", overrun, display_bank); end
  endtask
`else
  task automatic test_clear();
    int n;
    int bad;
    logic rd_seen;
    n = 0; rd_seen = 0;
    while (busy === 1'b1 && n < PIX + 50) begin
      if (mem_rd_en) rd_seen = 1;
      n++;
      tick(); read = (n == 10); pixel_number = 7;
      @(negedge clk);
    end
    read = 0;
    tests_run++; if (n !== PIX) begin tests_failed++; $display("FAIL clear_busy_cycles: got %0d want %0d", n, PIX); end
    tests_run++; if (rd_seen !== 1'b0) begin tests_failed++; $display("FAIL clear_read_access: got rd_en seen=%b want 0", rd_seen); end
    tests_run++; if (overrun !== 1'b1) begin tests_failed++; $display("FAIL clear_overrun: got %b want 1", overrun); end
    bad = 0;
    for (int p = 0; p < PIX; p++) if (ram_get(baddr(1, p)) !== BG) bad++;
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL clear_bank1_bg: got %0d pixels not %h, want 0", bad, BG); end
  endtask

  task automatic test_clear_reset();
    int n;
    logic wr_seen;
    tick(); frame_ready = 1;
    tick(); frame_ready = 0;
    @(negedge clk);
    n = 0;
    while (!(mem_wr_en === 1'b1 && mem_wr_addr === 20'(baddr(0, 999))) && n < PIX + 50) begin
      tick(); @(negedge clk); n++;
    end
    tests_run++; if (n >= PIX + 50) begin tests_failed++; $display("FAIL clear_reset_reach999: timed out after %0d cycles", n); end
    tick(); reset = 0;
    @(negedge clk);
    tests_run++; if (mem_wr_en !== 1'b0) begin tests_failed++; $display("FAIL clear_reset_abort_wr: got wr_en=%b want 0", mem_wr_en); end
    tick(); reset = 1;
    @(negedge clk);
    tests_run++; if (busy !== 1'b0 || display_bank !== 1'b1 || overrun !== 1'b0) begin tests_failed++; $display("FAIL clear_reset_state: got busy=%b bank=%b overrun=%b want 0/1/0", busy, display_bank, overrun); end
    wr_seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (mem_wr_en) wr_seen = 1;
      tick(); @(negedge clk);
    end
    tests_run++; if (wr_seen !== 1'b0) begin tests_failed++; $display("FAIL clear_reset_no_more_wr: got wr seen=%b want 0", wr_seen); end
    tests_run++; if (ram_get(baddr(0, 999)) !== BG || ram_get(baddr(0, 1000)) !== 24'h0) begin tests_failed++; $display("FAIL clear_reset_ram: got [999]=%h [1000]=%h want %h/000000", ram_get(baddr(0, 999)), ram_get(baddr(0, 1000)), BG); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_rmw();
    test_back_to_back();
    test_forwarding();
    test_write_ignored();
    test_swap();
`ifndef FB_CLEAR_ON_SWAP_EN
    test_overrun();
`else
    test_clear();
    test_clear_reset();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
